// File: rtl/jpeg_bit_buffer.sv
// Entropy-data bit buffer: strips JPEG byte stuffing and presents a left-aligned
// 32-bit window of the bitstream, consuming 0-32 bits per cycle.
module jpeg_bit_buffer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        img_start_i,
  input  logic        inport_valid_i,
  input  logic [7:0]  inport_data_i,
  input  logic        inport_last_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic        outport_last_o,
  input  logic [5:0]  outport_pop_i
);

  // Handshake: a byte transfers on a cycle where inport_valid_i && inport_accept_o;
  // bits are consumed on a cycle where outport_valid_o is high, by outport_pop_i.
  logic [63:0] buf_q, buf_d;
  logic [6:0]  count_q, count_d;
  logic        ff_q, ff_d;
  logic        last_q, last_d;

  logic [6:0]  pop_eff;
  logic [6:0]  cnt_pop;
  logic [63:0] buf_pop;
  logic        push;
  logic        stuffed;

  assign inport_accept_o = (count_q <= 7'd56) && !img_start_i;
  assign outport_valid_o = (count_q >= 7'd32) || (last_q && (count_q != 7'd0));
  assign outport_data_o  = buf_q[63:32];
  assign outport_last_o  = last_q && (count_q <= 7'd32);

  assign push    = inport_valid_i && inport_accept_o;
  assign stuffed = ff_q && (inport_data_i == 8'h00);

  always_comb begin
    pop_eff = 7'd0;
    if (outport_valid_o) begin
      pop_eff = (outport_pop_i > 6'd32) ? 7'd32 : {1'b0, outport_pop_i};
    end
    // Bits below count_q are always zero, so over-popping simply empties the buffer.
    buf_pop = buf_q << pop_eff;
    cnt_pop = (pop_eff >= count_q) ? 7'd0 : (count_q - pop_eff);

    buf_d   = buf_pop;
    count_d = cnt_pop;
    ff_d    = ff_q;
    last_d  = last_q;

    if (push) begin
      if (stuffed) begin
        ff_d = 1'b0;
      end else begin
        buf_d   = buf_pop | ({56'd0, inport_data_i} << (7'd56 - cnt_pop));
        count_d = cnt_pop + 7'd8;
        ff_d    = (inport_data_i == 8'hFF);
      end
      if (inport_last_i) begin
        last_d = 1'b1;
      end
    end

    if (img_start_i) begin
      buf_d   = 64'd0;
      count_d = 7'd0;
      ff_d    = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_q   <= 64'd0;
      count_q <= 7'd0;
      ff_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      ff_q    <= ff_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_jpeg_bit_buffer.sv
// Self-checking bench for jpeg_bit_buffer: bit-queue reference model compared every
// cycle, plus directed literal checks and randomized traffic.
module tb_jpeg_bit_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        img_start_i = 1'b0;
  logic        inport_valid_i = 1'b0;
  logic [7:0]  inport_data_i = 8'h00;
  logic        inport_last_i = 1'b0;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic        outport_last_o;
  logic [5:0]  outport_pop_i = 6'd0;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  jpeg_bit_buffer dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .img_start_i     (img_start_i),
    .inport_valid_i  (inport_valid_i),
    .inport_data_i   (inport_data_i),
    .inport_last_i   (inport_last_i),
    .inport_accept_o (inport_accept_o),
    .outport_valid_o (outport_valid_o),
    .outport_data_o  (outport_data_o),
    .outport_last_o  (outport_last_o),
    .outport_pop_i   (outport_pop_i)
  );

  // Clock / time limit
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: the de-stuffed stream as a queue of bits, oldest first.
  bit   mq[$];
  logic m_ff   = 1'b0;
  logic m_last = 1'b0;

  task automatic model_clear();
    mq.delete();
    m_ff   = 1'b0;
    m_last = 1'b0;
  endtask

  function automatic logic m_valid();
    return (mq.size() >= 32) || (m_last && mq.size() != 0);
  endfunction

  function automatic logic [31:0] m_data();
    logic [31:0] d = 32'd0;
    for (int i = 0; i < 32; i++) if (i < mq.size()) d[31-i] = mq[i];
    return d;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic l,
                            input logic [5:0] pop, input logic start);
    int p;
    logic acc;
    if (start) begin
      model_clear();
      return;
    end
    acc = (mq.size() <= 56);
    if (m_valid()) begin
      p = (pop > 32) ? 32 : int'(pop);
      for (int i = 0; i < p; i++) if (mq.size() > 0) void'(mq.pop_front());
    end
    if (v && acc) begin
      if (m_ff && d == 8'h00) begin
        m_ff = 1'b0;
      end else begin
        for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
        m_ff = (d == 8'hFF);
      end
      if (l) m_last = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare: outputs sampled on the falling edge, away from the active edge
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("accept", {31'd0, inport_accept_o}, {31'd0, (mq.size() <= 56) && !img_start_i});
      chk("valid",  {31'd0, outport_valid_o}, {31'd0, m_valid()});
      chk("last",   {31'd0, outport_last_o},  {31'd0, m_last && mq.size() <= 32});
      chk("data",   outport_data_o, m_data());
    end
  end

  // Driver: inputs change 1 time unit after the rising edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                     input logic [5:0] pop, input logic start);
    inport_valid_i = v;
    inport_data_i  = d;
    inport_last_i  = l;
    outport_pop_i  = pop;
    img_start_i    = start;
    @(posedge clk_i);
    model_step(v, d, l, pop, start);
    #1;
    inport_valid_i = 1'b0;
    inport_last_i  = 1'b0;
    outport_pop_i  = 6'd0;
    img_start_i    = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic pop(input logic [5:0] n);
    cyc(1'b0, 8'h00, 1'b0, n, 1'b0);
  endtask

  task automatic start();
    cyc(1'b0, 8'h00, 1'b0, 6'd0, 1'b1);
  endtask

  initial begin
    logic [63:0] pre;
    logic [7:0]  rb;
    // Reset values
    #2;
    chk("rst_accept", {31'd0, inport_accept_o}, 32'd1);
    chk("rst_valid",  {31'd0, outport_valid_o}, 32'd0);
    chk("rst_data",   outport_data_o, 32'd0);
    chk("rst_last",   {31'd0, outport_last_o},  32'd0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk_en = 1'b1;

    // Fill
    push(8'h12); push(8'h34); push(8'h56);
    chk("fill_valid3", {31'd0, outport_valid_o}, 32'd0);
    push(8'h78);
    chk("fill_valid4", {31'd0, outport_valid_o}, 32'd1);
    chk("fill_data", outport_data_o, 32'h12345678);
    pop(6'd32);
    chk("fill_empty", {31'd0, outport_valid_o}, 32'd0);

    // Stuffing
    start();
    push(8'hFF); push(8'h00); push(8'hAB); push(8'hCD); push(8'hEF);
    chk("stuff_data", outport_data_o, 32'hFFABCDEF);
    chk("stuff_valid", {31'd0, outport_valid_o}, 32'd1);
    start();
    push(8'hFF); push(8'hFF); push(8'h00); push(8'h00); push(8'h11);
    chk("stuff_ffff", outport_data_o, 32'hFFFF0011);

    // Variable pop
    start();
    pre = 64'hDEADBEEF_CAFEBABE;
    for (int i = 7; i >= 0; i--) push(pre[i*8 +: 8]);
    chk("full_accept", {31'd0, inport_accept_o}, 32'd0);
    pop(6'd5);
    chk("pop5_data", outport_data_o, 32'hD5B7DDF9);
    pop(6'd0);
    chk("pop0_data", outport_data_o, 32'hD5B7DDF9);
    pop(6'd32);
    pop(6'd32);
    pop(6'd40);

    // Full / back-pressure
    start();
    for (int i = 1; i <= 7; i++) push(8'(i));
    chk("bp_accept56", {31'd0, inport_accept_o}, 32'd1);
    push(8'h08);
    chk("bp_accept64", {31'd0, inport_accept_o}, 32'd0);
    pop(6'd8);
    chk("bp_accept_pop", {31'd0, inport_accept_o}, 32'd1);
    pop(6'd8);
    cyc(1'b1, 8'h5A, 1'b0, 6'd16, 1'b0);
    chk("bp_merge_data", outport_data_o, 32'h05060708);
    pop(6'd32);
    chk("bp_merge_byte", outport_data_o, 32'h5A000000);
    chk("bp_merge_valid", {31'd0, outport_valid_o}, 32'd0);

    // Tail
    start();
    push(8'hA1); push(8'hB2);
    cyc(1'b1, 8'hC3, 1'b1, 6'd0, 1'b0);
    chk("tail_valid", {31'd0, outport_valid_o}, 32'd1);
    chk("tail_last",  {31'd0, outport_last_o},  32'd1);
    chk("tail_data",  outport_data_o, 32'hA1B2C300);
    pop(6'd24);
    chk("tail_drop", {31'd0, outport_valid_o}, 32'd0);
    start();
    chk("tail_clear", {31'd0, outport_last_o}, 32'd0);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) push(8'h90 + 8'(i));
    #1 rst_i = 1'b0;
    model_clear();
    #1;
    chk("mrst_accept", {31'd0, inport_accept_o}, 32'd1);
    chk("mrst_valid",  {31'd0, outport_valid_o}, 32'd0);
    chk("mrst_data",   outport_data_o, 32'd0);
    chk("mrst_last",   {31'd0, outport_last_o},  32'd0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    chk("mrst_refill", outport_data_o, 32'h12345678);

    // Randomized traffic, biased towards 0xFF / 0x00 to exercise stuffing
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: rb = 8'hFF;
        1: rb = 8'h00;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      cyc(1'($urandom_range(0, 3) != 0), rb, 1'($urandom_range(0, 60) == 0),
          ($urandom_range(0, 9) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32)),
          1'($urandom_range(0, 150) == 0));
    end

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
